xbus_avm_bridge: RTL and testbench
==================================

# xbus_avm_bridge

Initiator-side bridge that turns NEORV32 external-bus (XBUS, Wishbone-style, single transfers) requests into Avalon-MM master transfers. It drives the `avm_*` slave port of the Qsys SDRAM subsystem. The bridge sits between the NEORV32 top level and `qsys_core`, and adds a bus timeout that reports an error back to the CPU.

## Interface
Clock/reset: one clock; reset is asynchronous and active-low (`clk_clk`, `reset_reset_n`).

Parameters:
- `TIMEOUT_CYCLES`, 255, max cycles a request may stall on `avm_waitrequest_i` before abort; range 1..65535.

Ports:
- `clk_clk`  in  1  system clock
- `reset_reset_n`  in  1  async active-low reset
- `xbus_adr_i`  in  32  byte address
- `xbus_dat_i`  in  32  write data
- `xbus_we_i`  in  1  1 = write, 0 = read
- `xbus_sel_i`  in  4  byte lanes
- `xbus_stb_i`  in  1  request strobe (one-cycle pulse per transfer)
- `xbus_cyc_i`  in  1  cycle valid; low = CPU abandoned the transfer
- `xbus_dat_o`  out  32  read data, valid with `xbus_ack_o`
- `xbus_ack_o`  out  1  one-cycle completion pulse
- `xbus_err_o`  out  1  one-cycle error pulse (timeout)
- `avm_cs_o`  out  1  chip select; high for the whole transfer
- `avm_address_o`  out  32  byte address, bits [1:0] forced to 0
- `avm_read_o`  out  1  read request
- `avm_write_o`  out  1  write request
- `avm_writedata_o`  out  32  write data
- `avm_byteenable_o`  out  4  byte enables
- `avm_waitrequest_i`  in  1  slave stall
- `avm_readdata_i`  in  32  read data, valid in the cycle read is accepted

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: on `xbus_stb_i & xbus_cyc_i`, register address, data, sel and we, then go to REQ. `stb` without `cyc` is ignored.
- REQ: `avm_cs_o` = 1. Exactly one of `avm_read_o`/`avm_write_o` is 1. Address, data and byteenable stay stable from registers.
  - Accept: `avm_waitrequest_i` = 0. For a read, capture `avm_readdata_i` into the data register. Go to RESP.
  - Timeout: `avm_waitrequest_i` = 1 and the stall counter equals `TIMEOUT_CYCLES`-1. Drop all `avm_*` strobes, set the error flag, go to RESP.
- RESP: pulse `xbus_ack_o` (normal) or `xbus_err_o` (timeout) for one cycle, then go to IDLE. Never both at once.
- Abort: if `xbus_cyc_i` falls during REQ, the Avalon transfer still completes (Avalon forbids withdrawing). RESP then emits no ack/err; the result is discarded.
- `stb` arriving while not IDLE is ignored (the CPU issues one outstanding transfer only).
- Stall counter: width clog2(TIMEOUT_CYCLES+1). Cleared on entry to REQ; increments each REQ cycle with waitrequest = 1; saturates and never wraps.
- `xbus_dat_o` holds the last read data until the next read completes; it is 0 after reset. Writes and errors leave it unchanged.

## Timing
- Reset: every output is 0, FSM = IDLE, counter = 0. This applies immediately on `reset_reset_n` low, even mid-transfer.
- Request latency: `stb` sampled at edge N; `avm_*` strobes are high during cycle N+1.
- Zero-wait read/write: accepted in cycle N+1; `xbus_ack_o` high in cycle N+2; next `stb` can be accepted in cycle N+3.
- With W wait cycles: ack in cycle N+2+W.
- Timeout: strobes are high for exactly `TIMEOUT_CYCLES` cycles; `xbus_err_o` is high in the cycle after the last of them.
- All outputs are registered; there is no combinational path from the xbus inputs to `avm_*`.

## Structure
- Package `xbus_avm_pkg`: FSM state enum (IDLE/REQ/RESP) and the `XBUS_DW`=32 / `XBUS_AW`=32 width constants.
- Sub-module `xbus_avm_timeout`: saturating stall counter with `clr`, `inc` and `expired` signals, parameterised by `TIMEOUT_CYCLES`.
- Everything else lives in the top FSM.

## Test plan
- Zero-wait write: adr 0x0000_0104, dat 0xDEADBEEF, sel 0xF, waitrequest held 0. Expect: write=1, address=0x104, byteenable=0xF for one cycle; ack 2 cycles after stb; err=0.
- Read with 3 wait cycles: slave returns 0x12345678 on the accept cycle. Expect: read high for 4 cycles, ack at stb+5, `xbus_dat_o`=0x12345678.
- Byte write: adr 0x0000_0203, sel 0x8. Expect: address=0x200, byteenable=0x8, data passed through unchanged.
- Timeout: TIMEOUT_CYCLES=16, waitrequest stuck at 1. Expect: read high for exactly 16 cycles, then err=1 for one cycle, ack=0, `xbus_dat_o` unchanged.
- Abort: cyc dropped one cycle after stb, 2 wait cycles. Expect: the Avalon read completes, no ack and no err; the next stb is served normally.
- Reset mid-transfer: assert reset_reset_n=0 during REQ. Expect: all outputs 0 asynchronously; after release, the FSM is IDLE and a new read completes normally.

Source files
------------

// File: rtl/xbus_avm_pkg.sv
// Shared types and widths for the XBUS -> Avalon-MM initiator bridge.
package xbus_avm_pkg;
  localparam int XBUS_DW = 32;
  localparam int XBUS_AW = 32;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic [XBUS_AW-1:0]   adr;
    logic [XBUS_DW-1:0]   dat;
    logic [XBUS_DW/8-1:0] sel;
    logic                 we;
  } xbus_req_t;
endpackage

// File: rtl/xbus_avm_bridge_if.sv
// XBUS request side plus Avalon-MM master side of the bridge.
// slave = the bridge's view (XBUS slave / Avalon master); master = the CPU + SDRAM side.
interface xbus_avm_bridge_if;
  logic [xbus_avm_pkg::XBUS_AW-1:0]   xbus_adr_i;
  logic [xbus_avm_pkg::XBUS_DW-1:0]   xbus_dat_i;
  logic                               xbus_we_i;
  logic [xbus_avm_pkg::XBUS_DW/8-1:0] xbus_sel_i;
  logic                               xbus_stb_i;
  logic                               xbus_cyc_i;
  logic [xbus_avm_pkg::XBUS_DW-1:0]   xbus_dat_o;
  logic                               xbus_ack_o;
  logic                               xbus_err_o;
  logic                               avm_cs_o;
  logic [xbus_avm_pkg::XBUS_AW-1:0]   avm_address_o;
  logic                               avm_read_o;
  logic                               avm_write_o;
  logic [xbus_avm_pkg::XBUS_DW-1:0]   avm_writedata_o;
  logic [xbus_avm_pkg::XBUS_DW/8-1:0] avm_byteenable_o;
  logic                               avm_waitrequest_i;
  logic [xbus_avm_pkg::XBUS_DW-1:0]   avm_readdata_i;

  modport slave (
    input  xbus_adr_i, xbus_dat_i, xbus_we_i, xbus_sel_i, xbus_stb_i, xbus_cyc_i,
           avm_waitrequest_i, avm_readdata_i,
    output xbus_dat_o, xbus_ack_o, xbus_err_o,
           avm_cs_o, avm_address_o, avm_read_o, avm_write_o, avm_writedata_o, avm_byteenable_o
  );

  modport master (
    output xbus_adr_i, xbus_dat_i, xbus_we_i, xbus_sel_i, xbus_stb_i, xbus_cyc_i,
           avm_waitrequest_i, avm_readdata_i,
    input  xbus_dat_o, xbus_ack_o, xbus_err_o,
           avm_cs_o, avm_address_o, avm_read_o, avm_write_o, avm_writedata_o, avm_byteenable_o
  );
endinterface

// File: rtl/xbus_avm_timeout.sv
// Saturating stall counter; expired marks the last stall cycle a request may spend.
module xbus_avm_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                                    cnt <= '0;
    else if (clr)                                   cnt <= '0;
    else if (inc && (cnt != CW'(TIMEOUT_CYCLES)))   cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/xbus_avm_bridge.sv
// XBUS single-transfer requests -> Avalon-MM master transfers, with a stall timeout
// that returns an error pulse to the CPU.
module xbus_avm_bridge
  import xbus_avm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  xbus_avm_bridge_if.slave  bus
);
  state_t              state, state_nxt;
  xbus_req_t           req_q;
  logic [XBUS_DW-1:0]  rdata_q;
  logic                err_q, err_nxt;
  logic                abort_q, abort_nxt;
  logic                start, accept, timeout, expired;

  assign start   = bus.xbus_stb_i & bus.xbus_cyc_i;
  assign accept  = (state == REQ) & ~bus.avm_waitrequest_i;
  assign timeout = (state == REQ) & bus.avm_waitrequest_i & expired;

  xbus_avm_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .gclk    (clk_clk),
    .grst_n  (reset_reset_n),
    .clr     ((state == IDLE) & start),
    .inc     ((state == REQ) & bus.avm_waitrequest_i),
    .expired (expired)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_q   <= err_nxt;
      abort_q <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    abort_nxt = abort_q;
    case (state)
      IDLE: if (start) begin
        state_nxt = REQ;
        err_nxt   = 1'b0;
        abort_nxt = 1'b0;
      end
      REQ: begin
        // Avalon cannot withdraw a request; an abandoned cycle only suppresses the response.
        if (!bus.xbus_cyc_i) abort_nxt = 1'b1;
        if (accept) state_nxt = RESP;
        else if (timeout) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      if ((state == IDLE) && start)
        req_q <= '{adr: bus.xbus_adr_i, dat: bus.xbus_dat_i,
                   sel: bus.xbus_sel_i, we: bus.xbus_we_i};
      // Read data from an abandoned transfer is discarded, keeping the last delivered value.
      if (accept && !req_q.we && !abort_q && bus.xbus_cyc_i)
        rdata_q <= bus.avm_readdata_i;
    end
  end

  assign bus.avm_cs_o         = (state == REQ);
  assign bus.avm_read_o       = (state == REQ) & ~req_q.we;
  assign bus.avm_write_o      = (state == REQ) &  req_q.we;
  assign bus.avm_address_o    = {req_q.adr[XBUS_AW-1:2], 2'b00};
  assign bus.avm_writedata_o  = req_q.dat;
  assign bus.avm_byteenable_o = req_q.sel;
  assign bus.xbus_dat_o       = rdata_q;
  assign bus.xbus_ack_o       = (state == RESP) & ~err_q & ~abort_q;
  assign bus.xbus_err_o       = (state == RESP) &  err_q & ~abort_q;
endmodule

// File: tb/tb_xbus_avm_bridge.sv
// Directed bench for xbus_avm_bridge: scoreboarded transfers, timeout, abort, async reset.
module tb_xbus_avm_bridge;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbus_avm_bridge_if bus();

  xbus_avm_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus.slave)
  );

  typedef struct {
    int          strobes;
    int          n_ack;
    int          n_err;
    int          resp_cyc;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] dat_model = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".cs"},    32'(bus.avm_cs_o), 32'h0);
    chk({tag, ".rd"},    32'(bus.avm_read_o), 32'h0);
    chk({tag, ".wr"},    32'(bus.avm_write_o), 32'h0);
    chk({tag, ".addr"},  bus.avm_address_o, 32'h0);
    chk({tag, ".wdat"},  bus.avm_writedata_o, 32'h0);
    chk({tag, ".be"},    32'(bus.avm_byteenable_o), 32'h0);
    chk({tag, ".ack"},   32'(bus.xbus_ack_o), 32'h0);
    chk({tag, ".err"},   32'(bus.xbus_err_o), 32'h0);
    chk({tag, ".dat_o"}, bus.xbus_dat_o, 32'h0);
  endtask

  // One XBUS transfer; w = wait cycles before the slave accepts (large = stuck).
  task automatic xfer(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                      input logic we, input logic [3:0] sel, input int w,
                      input logic [31:0] rdat, input bit abort, input exp_t e);
    int   strobes = 0;
    int   n_ack = 0;
    int   n_err = 0;
    int   both = 0;
    int   resp = -1;
    logic wr;
    exp_t got;
    sb.push_back(e);
    bus.xbus_adr_i = adr;
    bus.xbus_dat_i = dat;
    bus.xbus_we_i  = we;
    bus.xbus_sel_i = sel;
    bus.xbus_stb_i = 1'b1;
    bus.xbus_cyc_i = 1'b1;
    bus.avm_waitrequest_i = (w > 0);
    bus.avm_readdata_i    = (w > 0) ? 32'h0 : rdat;
    @(posedge clk); #1;
    bus.xbus_stb_i = 1'b0;
    if (abort) bus.xbus_cyc_i = 1'b0;
    chk({tag, ".cs"},   32'(bus.avm_cs_o), 32'h1);
    chk({tag, ".rd"},   32'(bus.avm_read_o), 32'(!we));
    chk({tag, ".wr"},   32'(bus.avm_write_o), 32'(we));
    chk({tag, ".addr"}, bus.avm_address_o, adr & 32'hFFFF_FFFC);
    chk({tag, ".be"},   32'(bus.avm_byteenable_o), 32'(sel));
    if (we) chk({tag, ".wdat"}, bus.avm_writedata_o, dat);
    for (int c = 1; c <= 30; c++) begin
      if (bus.avm_read_o || bus.avm_write_o) begin
        wr = (strobes < w);
        bus.avm_waitrequest_i = wr;
        bus.avm_readdata_i    = wr ? 32'h0 : rdat;
        strobes++;
      end else begin
        bus.avm_waitrequest_i = 1'b0;
        bus.avm_readdata_i    = 32'h0;
      end
      if (bus.xbus_ack_o) begin n_ack++; if (resp < 0) resp = c; end
      if (bus.xbus_err_o) begin n_err++; if (resp < 0) resp = c; end
      if (bus.xbus_ack_o && bus.xbus_err_o) both++;
      @(posedge clk); #1;
    end
    bus.xbus_cyc_i = 1'b1;
    bus.avm_waitrequest_i = 1'b0;
    got = sb.pop_front();
    chk({tag, ".strobes"}, 32'(strobes), 32'(got.strobes));
    chk({tag, ".n_ack"},   32'(n_ack), 32'(got.n_ack));
    chk({tag, ".n_err"},   32'(n_err), 32'(got.n_err));
    chk({tag, ".resp"},    32'(resp), 32'(got.resp_cyc));
    chk({tag, ".both"},    32'(both), 32'h0);
    chk({tag, ".dat_o"},   bus.xbus_dat_o, got.dat);
  endtask

  initial begin
    exp_t e;
    bus.xbus_adr_i = '0; bus.xbus_dat_i = '0; bus.xbus_we_i = 1'b0;
    bus.xbus_sel_i = '0; bus.xbus_stb_i = 1'b0; bus.xbus_cyc_i = 1'b0;
    bus.avm_waitrequest_i = 1'b0; bus.avm_readdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // stb without cyc must not start a transfer
    bus.xbus_stb_i = 1'b1;
    @(posedge clk); #1;
    bus.xbus_stb_i = 1'b0;
    chk("stb_no_cyc.cs", 32'(bus.avm_cs_o), 32'h0);

    e = '{strobes: 1, n_ack: 1, n_err: 0, resp_cyc: 2, dat: dat_model};
    xfer("wr0", 32'h0000_0104, 32'hDEAD_BEEF, 1'b1, 4'hF, 0, 32'h0, 1'b0, e);

    dat_model = 32'h1234_5678;
    e = '{strobes: 4, n_ack: 1, n_err: 0, resp_cyc: 5, dat: dat_model};
    xfer("rd3", 32'h0000_0040, 32'h0, 1'b0, 4'hF, 3, 32'h1234_5678, 1'b0, e);

    e = '{strobes: 1, n_ack: 1, n_err: 0, resp_cyc: 2, dat: dat_model};
    xfer("wrb", 32'h0000_0203, 32'hA5A5_1234, 1'b1, 4'h8, 0, 32'h0, 1'b0, e);

    e = '{strobes: TO, n_ack: 0, n_err: 1, resp_cyc: TO + 1, dat: dat_model};
    xfer("tmo", 32'h0000_0800, 32'h0, 1'b0, 4'hF, 1000, 32'hFFFF_0000, 1'b0, e);

    e = '{strobes: 3, n_ack: 0, n_err: 0, resp_cyc: -1, dat: dat_model};
    xfer("abort", 32'h0000_0900, 32'h0, 1'b0, 4'hF, 2, 32'h0BAD_F00D, 1'b1, e);

    dat_model = 32'hCAFE_F00D;
    e = '{strobes: 1, n_ack: 1, n_err: 0, resp_cyc: 2, dat: dat_model};
    xfer("post_abort", 32'h0000_0A04, 32'h0, 1'b0, 4'hF, 0, 32'hCAFE_F00D, 1'b0, e);

    // Reset in the middle of a stalled write
    bus.xbus_adr_i = 32'h0000_0300; bus.xbus_dat_i = 32'h1111_2222;
    bus.xbus_we_i = 1'b1; bus.xbus_sel_i = 4'hF;
    bus.xbus_stb_i = 1'b1; bus.xbus_cyc_i = 1'b1; bus.avm_waitrequest_i = 1'b1;
    @(posedge clk); #1;
    bus.xbus_stb_i = 1'b0;
    chk("mid.cs", 32'(bus.avm_cs_o), 32'h1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    dat_model = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.avm_waitrequest_i = 1'b0;
    @(posedge clk); #1;

    dat_model = 32'h600D_D00D;
    e = '{strobes: 2, n_ack: 1, n_err: 0, resp_cyc: 3, dat: dat_model};
    xfer("post_rst", 32'h0000_0C08, 32'h0, 1'b0, 4'hF, 1, 32'h600D_D00D, 1'b0, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
